// File: rtl/lsq_load_rs.sv
// Single-entry load reservation station: operand wakeup, AGU handoff,
// older-store check, then store-to-load forwarding or data-cache issue.

package lsq_load_rs_pkg;
    localparam int PIPE_WIDTH    = 5;
    localparam int TAG_WIDTH     = 6;
    localparam int CPU_DATA_BITS = 32;
    localparam int PC_BITS       = 32;

    typedef struct packed {
        logic                     is_renamed;
        logic [TAG_WIDTH-1:0]     tag;
        logic [CPU_DATA_BITS-1:0] data;
    } operand_t;

    typedef struct packed {
        logic                 is_valid;
        logic                 agu_comp;
        logic [PC_BITS-1:0]   pc;
        logic [TAG_WIDTH-1:0] dest_tag;
        operand_t             src_0_a;
        operand_t             src_0_b;
        operand_t             src_1_a;
    } instruction_t;

    typedef struct packed {
        logic                     is_valid;
        logic                     exception;
        logic [TAG_WIDTH-1:0]     dest_tag;
        logic [CPU_DATA_BITS-1:0] result;
    } writeback_packet_t;
endpackage

// Per store-queue entry classification against the waiting load.
module lsq_load_rs_stq_cmp
    import lsq_load_rs_pkg::*;
(
    input  logic                     st_valid,
    input  logic [PC_BITS-1:0]       st_pc,
    input  logic                     st_comp,
    input  logic [CPU_DATA_BITS-1:0] st_addr,
    input  logic [PC_BITS-1:0]       ld_pc,
    input  logic [CPU_DATA_BITS-1:0] ld_addr,
    output logic                     unknown,
    output logic                     match
);
    logic older;
    assign older   = st_valid && (st_pc < ld_pc);
    assign unknown = older && !st_comp;
    assign match   = older && st_comp && (st_addr == ld_addr);
endmodule

module lsq_load_rs
    import lsq_load_rs_pkg::*;
#(
    parameter int STQ_DEPTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 cache_stall,
    input  instruction_t                         rs_entry,
    input  logic                                 rs_we,
    output logic                                 rs_write_rdy,
    output logic                                 rs_read_rdy,
    output instruction_t                         execute_pkt,
    input  logic                                 alu_re,
    input  writeback_packet_t [PIPE_WIDTH-1:0]   cdb_ports,
    output logic                                 agu_read_rdy,
    output instruction_t                         agu_execute_pkt,
    input  writeback_packet_t                    agu_port,
    input  instruction_t      [STQ_DEPTH-1:0]    store_q,
    input  logic                                 forward_re,
    output writeback_packet_t                    forward_pkt,
    output logic                                 forward_rdy
);
    typedef enum logic [1:0] {EMPTY, WAIT_OPS, WAIT_ADDR, CHECK} state_t;

    state_t       state, state_nxt;
    instruction_t entry, entry_nxt;

    logic [STQ_DEPTH-1:0]     st_unknown, st_match;
    logic                     any_unknown, any_match, y_rdy;
    logic [PC_BITS-1:0]       y_pc;
    logic [CPU_DATA_BITS-1:0] y_data;

    // Fields of the buses that this station never looks at.
    logic unused_bits;
    assign unused_bits = ^{agu_port, cdb_ports, store_q};

    // Descending scan so the lowest matching CDB port is applied last and wins.
    function automatic operand_t wake(operand_t op, writeback_packet_t [PIPE_WIDTH-1:0] cdb);
        operand_t r;
        r = op;
        for (int i = PIPE_WIDTH - 1; i >= 0; i--) begin
            if (op.is_renamed && cdb[i].is_valid && cdb[i].dest_tag == op.tag) begin
                r.data       = cdb[i].result;
                r.is_renamed = 1'b0;
            end
        end
        return r;
    endfunction

    genvar g;
    generate
        for (g = 0; g < STQ_DEPTH; g++) begin : g_stq
            lsq_load_rs_stq_cmp u_cmp (
                .st_valid (store_q[g].is_valid),
                .st_pc    (store_q[g].pc),
                .st_comp  (store_q[g].agu_comp),
                .st_addr  (store_q[g].src_0_a.data),
                .ld_pc    (entry.pc),
                .ld_addr  (entry.src_0_a.data),
                .unknown  (st_unknown[g]),
                .match    (st_match[g])
            );
        end
    endgenerate

    // Pick the youngest older store whose address hits the load.
    always_comb begin
        any_unknown = |st_unknown;
        any_match   = 1'b0;
        y_pc        = '0;
        y_rdy       = 1'b0;
        y_data      = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (st_match[i] && (!any_match || store_q[i].pc > y_pc)) begin
                any_match = 1'b1;
                y_pc      = store_q[i].pc;
                y_rdy     = !store_q[i].src_1_a.is_renamed;
                y_data    = store_q[i].src_1_a.data;
            end
        end
    end

    assign rs_write_rdy    = (state == EMPTY);
    assign agu_read_rdy    = (state == WAIT_OPS) && !entry.src_0_a.is_renamed
                             && !entry.src_0_b.is_renamed;
    assign agu_execute_pkt = entry;
    assign execute_pkt     = entry;
    assign forward_rdy     = (state == CHECK) && !any_unknown && any_match && y_rdy;
    assign rs_read_rdy     = (state == CHECK) && !any_unknown && !any_match && !cache_stall;

    // Forward packet is all-zero unless a forward is actually on offer.
    always_comb begin
        forward_pkt = '0;
        if (forward_rdy) begin
            forward_pkt.is_valid = 1'b1;
            forward_pkt.dest_tag = entry.dest_tag;
            forward_pkt.result   = y_data;
        end
    end

    // Next-state and entry update; flush overrides everything else.
    always_comb begin
        state_nxt = state;
        entry_nxt = entry;
        case (state)
            EMPTY: if (rs_we) begin
                entry_nxt         = rs_entry;
                entry_nxt.src_0_a = wake(rs_entry.src_0_a, cdb_ports);
                entry_nxt.src_0_b = wake(rs_entry.src_0_b, cdb_ports);
                state_nxt         = WAIT_OPS;
            end
            WAIT_OPS: begin
                entry_nxt.src_0_a = wake(entry.src_0_a, cdb_ports);
                entry_nxt.src_0_b = wake(entry.src_0_b, cdb_ports);
                if (agu_read_rdy) state_nxt = WAIT_ADDR;
            end
            WAIT_ADDR: if (agu_port.is_valid) begin
                entry_nxt.src_0_a.data = agu_port.result;
                state_nxt              = CHECK;
            end
            CHECK: if ((forward_re && forward_rdy) || (alu_re && rs_read_rdy)) begin
                entry_nxt = '0;
                state_nxt = EMPTY;
            end
            default: begin
                entry_nxt = '0;
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            entry_nxt = '0;
            state_nxt = EMPTY;
        end
    end

    // State and entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            entry <= '0;
        end else begin
            state <= state_nxt;
            entry <= entry_nxt;
        end
    end
endmodule

// File: tb/tb_lsq_load_rs.sv
// Directed and randomized checks of the load reservation station.
module tb_lsq_load_rs;
    import lsq_load_rs_pkg::*;
    localparam int STQ = 5;

    logic clk = 1'b0;
    logic rst, flush, cache_stall, rs_we, alu_re, forward_re;
    instruction_t                       rs_entry;
    writeback_packet_t [PIPE_WIDTH-1:0] cdb_ports;
    writeback_packet_t                  agu_port;
    instruction_t      [STQ-1:0]        store_q;
    logic              rs_write_rdy, rs_read_rdy, agu_read_rdy, forward_rdy;
    instruction_t      execute_pkt, agu_execute_pkt;
    writeback_packet_t forward_pkt;

    int compared   = 0;
    int mismatched = 0;

    lsq_load_rs #(.STQ_DEPTH(STQ)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
        .rs_entry(rs_entry), .rs_we(rs_we), .rs_write_rdy(rs_write_rdy),
        .rs_read_rdy(rs_read_rdy), .execute_pkt(execute_pkt), .alu_re(alu_re),
        .cdb_ports(cdb_ports), .agu_read_rdy(agu_read_rdy),
        .agu_execute_pkt(agu_execute_pkt), .agu_port(agu_port),
        .store_q(store_q), .forward_re(forward_re), .forward_pkt(forward_pkt),
        .forward_rdy(forward_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_load(input logic [31:0] pc, input logic [31:0] base, input logic ren,
                              input logic [5:0] btag, input logic [31:0] imm, input logic [5:0] dtag);
        rs_entry                    = '0;
        rs_entry.is_valid           = 1'b1;
        rs_entry.pc                 = pc;
        rs_entry.dest_tag           = dtag;
        rs_entry.src_0_a.is_renamed = ren;
        rs_entry.src_0_a.tag        = btag;
        rs_entry.src_0_a.data       = base;
        rs_entry.src_0_b.data       = imm;
        rs_we = 1'b1;
        tick();
        rs_we    = 1'b0;
        rs_entry = '0;
    endtask

    task automatic agu_deliver(input logic [31:0] addr);
        agu_port          = '0;
        agu_port.is_valid = 1'b1;
        agu_port.result   = addr;
        agu_port.dest_tag = 6'h3f;
        tick();
        agu_port = '0;
    endtask

    function automatic instruction_t mk_st(input logic v, input logic [31:0] pc, input logic comp,
                                           input logic [31:0] addr, input logic [31:0] data,
                                           input logic rdy);
        instruction_t s;
        s                    = '0;
        s.is_valid           = v;
        s.pc                 = pc;
        s.agu_comp           = comp;
        s.src_0_a.data       = addr;
        s.src_1_a.data       = data;
        s.src_1_a.is_renamed = !rdy;
        return s;
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_wrdy"}, rs_write_rdy, 1);
        chk({pfx, "_rrdy"}, rs_read_rdy, 0);
        chk({pfx, "_agurdy"}, agu_read_rdy, 0);
        chk({pfx, "_fwdrdy"}, forward_rdy, 0);
        chk({pfx, "_exec_zero"}, execute_pkt === '0, 1);
        chk({pfx, "_agupkt_zero"}, agu_execute_pkt === '0, 1);
        chk({pfx, "_fwdpkt_zero"}, forward_pkt === '0, 1);
    endtask

    initial begin
        logic [31:0] lpc, laddr, exp_data;
        logic        exp_fwd, exp_rd;
        int          pcs[STQ];
        instruction_t older_q[$];

        rst = 1'b1; flush = 0; cache_stall = 0; rs_we = 0; alu_re = 0; forward_re = 0;
        rs_entry = '0; cdb_ports = '0; agu_port = '0; store_q = '0;
        tick(); tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Forwarding from an older store with ready data
        write_load(20, 0, 0, 0, 0, 3);
        chk("t1_wrdy_after_we", rs_write_rdy, 0);
        chk("t1_agu_rdy", agu_read_rdy, 1);
        chk("t1_agu_pc", agu_execute_pkt.pc, 20);
        tick();
        chk("t1_agu_rdy_after_handoff", agu_read_rdy, 0);
        agu_deliver(32'hFFFF);
        store_q[0] = mk_st(1, 18, 1, 32'hFFFF, 32'h1234, 1);
        #1;
        chk("t1_fwd_rdy", forward_rdy, 1);
        chk("t1_fwd_data", forward_pkt.result, 32'h1234);
        chk("t1_fwd_tag", forward_pkt.dest_tag, 3);
        chk("t1_fwd_valid", forward_pkt.is_valid, 1);
        chk("t1_fwd_exc", forward_pkt.exception, 0);
        chk("t1_rd_rdy", rs_read_rdy, 0);
        forward_re = 1; tick(); forward_re = 0;
        chk("t1_wrdy_freed", rs_write_rdy, 1);
        chk("t1_fwd_gone", forward_rdy, 0);
        store_q = '0;

        // Cache issue with empty store queue, and cache_stall masking
        write_load(20, 0, 0, 0, 0, 4);
        tick();
        agu_deliver(32'hFFFF);
        chk("t2_rd_rdy", rs_read_rdy, 1);
        chk("t2_exec_addr", execute_pkt.src_0_a.data, 32'hFFFF);
        chk("t2_no_fwd", forward_rdy, 0);
        cache_stall = 1; #1;
        chk("t2_stall_rd", rs_read_rdy, 0);
        alu_re = 1; tick();
        chk("t2_stall_ignored", rs_write_rdy, 0);
        cache_stall = 0; #1;
        chk("t2_rd_again", rs_read_rdy, 1);
        tick(); alu_re = 0;
        chk("t2_wrdy_freed", rs_write_rdy, 1);

        // Same-cycle CDB bypass at write, lowest port wins
        cdb_ports[0] = '{is_valid: 1, exception: 0, dest_tag: 8, result: 32'h40};
        cdb_ports[2] = '{is_valid: 1, exception: 0, dest_tag: 8, result: 32'h99};
        write_load(20, 0, 1, 8, 4, 5);
        cdb_ports = '0;
        chk("t3_bypass_rdy", agu_read_rdy, 1);
        chk("t3_bypass_data", agu_execute_pkt.src_0_a.data, 32'h40);
        chk("t3_bypass_ren", agu_execute_pkt.src_0_a.is_renamed, 0);
        flush = 1; tick(); flush = 0;
        chk("t3_flush_wrdy", rs_write_rdy, 1);

        // Wakeup while waiting in the station
        write_load(20, 32'h10, 1, 9, 0, 6);
        chk("t3_pending", agu_read_rdy, 0);
        tick();
        chk("t3_still_pending", agu_read_rdy, 0);
        cdb_ports[1] = '{is_valid: 1, exception: 0, dest_tag: 9, result: 32'h80};
        tick();
        cdb_ports = '0;
        chk("t3_woken", agu_read_rdy, 1);
        chk("t3_woken_data", agu_execute_pkt.src_0_a.data, 32'h80);

        // Flush in WAIT_ADDR; later AGU pulse must be ignored
        tick();
        flush = 1; tick(); flush = 0;
        chk("t5_flush_wrdy", rs_write_rdy, 1);
        chk("t5_flush_agu", agu_read_rdy, 0);
        agu_deliver(32'h500);
        chk("t5_stale_wrdy", rs_write_rdy, 1);
        chk("t5_stale_rd", rs_read_rdy, 0);
        chk("t5_stale_fwd", forward_rdy, 0);
        rs_entry.is_valid = 1; rs_we = 1; flush = 1; tick();
        rs_we = 0; flush = 0; rs_entry = '0;
        chk("t5_flush_over_we", rs_write_rdy, 1);

        // Unknown older store blocks; younger store ignored; youngest match chosen
        write_load(20, 0, 0, 0, 0, 7);
        tick();
        agu_deliver(32'h100);
        store_q[0] = mk_st(1, 10, 0, 0, 0, 1);
        store_q[1] = mk_st(1, 22, 1, 32'h100, 32'h77, 1);
        #1;
        chk("t4_unknown_rd", rs_read_rdy, 0);
        chk("t4_unknown_fwd", forward_rdy, 0);
        store_q[0] = mk_st(1, 10, 1, 32'h200, 0, 1);
        #1;
        chk("t4_younger_ignored_rd", rs_read_rdy, 1);
        chk("t4_younger_ignored_fwd", forward_rdy, 0);
        store_q[2] = mk_st(1, 15, 1, 32'h100, 32'hAA, 1);
        store_q[3] = mk_st(1, 17, 1, 32'h100, 32'hBB, 0);
        #1;
        chk("t4_youngest_notrdy_fwd", forward_rdy, 0);
        chk("t4_youngest_notrdy_rd", rs_read_rdy, 0);
        store_q[3].src_1_a.is_renamed = 0;
        #1;
        chk("t4_youngest_fwd", forward_rdy, 1);
        chk("t4_youngest_data", forward_pkt.result, 32'hBB);

        // Reset mid-CHECK
        rst = 1; tick();
        chk_reset_outputs("t6");
        rst = 0; store_q = '0; tick();

        // Randomized loads against a rule-level model
        for (int it = 0; it < 40; it++) begin
            lpc   = 32'($urandom_range(16, 48));
            laddr = 32'h100 + 32'(4 * $urandom_range(0, 2));
            write_load(lpc, $urandom, 0, 0, $urandom, 6'($urandom_range(0, 63)));
            chk("r_agu_rdy", agu_read_rdy, 1);
            tick();
            repeat ($urandom_range(0, 3)) tick();
            chk("r_wait_addr_wrdy", rs_write_rdy, 0);
            agu_deliver(laddr);
            for (int i = 0; i < STQ; i++) begin
                bit dup;
                do begin
                    pcs[i] = $urandom_range(0, 63);
                    dup = 0;
                    for (int j = 0; j < i; j++) if (pcs[j] == pcs[i]) dup = 1;
                end while (dup);
                store_q[i] = mk_st($urandom_range(0, 3) != 0, 32'(pcs[i]), $urandom_range(0, 3) != 0,
                                   32'h100 + 32'(4 * $urandom_range(0, 2)), $urandom,
                                   $urandom_range(0, 3) != 0);
            end
            cache_stall = ($urandom_range(0, 3) == 0);
            #1;
            // Model: gather older stores, then decide
            older_q.delete();
            for (int i = 0; i < STQ; i++)
                if (store_q[i].is_valid && store_q[i].pc < lpc) older_q.push_back(store_q[i]);
            exp_fwd = 0; exp_rd = 0; exp_data = '0;
            begin
                bit blocked, hit;
                logic [31:0] best_pc;
                blocked = 0; hit = 0; best_pc = 0;
                foreach (older_q[k]) if (!older_q[k].agu_comp) blocked = 1;
                if (!blocked) begin
                    foreach (older_q[k]) begin
                        if (older_q[k].src_0_a.data == laddr && (!hit || older_q[k].pc > best_pc)) begin
                            hit = 1;
                            best_pc = older_q[k].pc;
                            exp_fwd = !older_q[k].src_1_a.is_renamed;
                            exp_data = older_q[k].src_1_a.data;
                        end
                    end
                    if (!hit) exp_rd = !cache_stall;
                end
            end
            chk("r_fwd_rdy", forward_rdy, exp_fwd);
            chk("r_rd_rdy", rs_read_rdy, exp_rd);
            if (exp_fwd) chk("r_fwd_data", forward_pkt.result, exp_data);
            if (exp_fwd) forward_re = 1;
            else if (exp_rd) alu_re = 1;
            else begin
                alu_re = 1; forward_re = 1;
                tick();
                alu_re = 0; forward_re = 0;
                chk("r_hold", rs_write_rdy, 0);
                flush = 1;
            end
            tick();
            alu_re = 0; forward_re = 0; flush = 0; cache_stall = 0; store_q = '0;
            chk("r_freed", rs_write_rdy, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
